side_buffer_fifo: RTL and testbench
===================================

Name: side_buffer_fifo

Overview:
- Clocked, parametrised successor of the MinBD side buffer.
- Holds flits diverted out of the router pipeline in a DEPTH-entry circular FIFO and reinjects them in order when the channel offers a free slot.
- A starvation counter raises a redirect request when reinjection is blocked too long, so upstream frees a slot.
- Sits between the buffer-eject stage and the redirect/inject stage.

Parameters:
- FLIT_W, 11, flit width in bits.
- DEPTH, 6, FIFO entries (>=2, need not be a power of two).
- STARVE_LIMIT, 8, consecutive blocked cycles before force_redirect asserts (>=1).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  eject stage offers a flit.
- in_flit  in  FLIT_W  flit offered.
- in_ready  out  1  buffer accepts in_flit this cycle.
- slot_free  in  1  channel has an empty slot for reinjection this cycle.
- out_valid  out  1  buffer drives a flit for reinjection.
- out_flit  out  FLIT_W  head flit.
- force_redirect  out  1  request to upstream to redirect a flit and create a slot.
- count  out  CNT_W  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async assert, sync deassert handled externally): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, out_valid=0, force_redirect=0, starve_cnt=0, state=IDLE. Storage contents are don't-care. Reset mid-operation discards all held flits.
- Output timing:
  - out_valid = !empty; out_flit = mem[rd_ptr]. Both are combinational from registers, so the head is visible in the cycle after its push (1-cycle latency).
- Pop and push:
  - pop = out_valid & slot_free; rd_ptr advances on the clock.
  - in_ready = !full | pop. A push into a full buffer is allowed only in the same cycle as a pop.
  - push = in_valid & in_ready. The flit is written at wr_ptr and wr_ptr advances.
- Pointers wrap DEPTH-1 -> 0 explicitly; modulo-2^n wrap is not used.
- Count update: count += push - pop. Simultaneous push and pop leave count unchanged. Simultaneous push and pop on empty is impossible (pop needs !empty).
- in_valid while !in_ready: the flit is not taken, upstream must hold it, and no state changes.
- FSM states:
  - IDLE: empty. starve_cnt=0. On push -> WAIT.
  - WAIT: nonempty, not starved.
    - If pop and the buffer becomes empty -> IDLE.
    - Else if pop -> starve_cnt=0.
    - Else starve_cnt++; when starve_cnt == STARVE_LIMIT-1 and !slot_free -> STARVED.
  - STARVED: force_redirect=1 (registered, so it asserts the cycle after entry).
    - On pop: starve_cnt=0, force_redirect drops the next cycle, -> WAIT, or -> IDLE if now empty.
    - starve_cnt saturates; it does not wrap.
- force_redirect is never asserted while empty.

Optional Feature:
- Macro: SIDE_BUF_STATS_EN.
- Defined: two extra outputs.
  - hwm (CNT_W): occupancy high-water mark, reset 0, updated to max(hwm, next count).
  - starve_events (16 bits): increments on each WAIT->STARVED transition and saturates at 16'hFFFF.
- Undefined: the ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package side_buf_pkg:
  - flit width default;
  - FSM state enum (IDLE, WAIT, STARVED) as a 2-bit typedef;
  - pointer-increment-with-wrap function.
- One natural sub-module: side_buf_mem, a DEPTH x FLIT_W register array with write port and async read port, no reset on data.
- Control, pointers, FSM and counters live in side_buffer_fifo.

Test Plan:
- Reset then push 11'h123, 11'h456 with slot_free=0 -> count=2, out_flit=11'h123, force_redirect=0. Then slot_free=1 for 2 cycles -> pops 123 then 456, empty=1, state IDLE.
- Fill to 6 with slot_free=0 -> full=1, in_ready=0. Offered flit 11'h7FF is not accepted and count stays 6.
- Full buffer, in_valid=1 and slot_free=1 same cycle -> pop and push together, count stays 6, FIFO order preserved across the wr_ptr 5->0 wrap.
- One flit held, slot_free=0 for 8 cycles -> force_redirect=1 from the 9th cycle. slot_free=1 -> pop, force_redirect=0 next cycle, empty=1.
- Assert rst_n=0 mid-stream with count=4 and force_redirect=1 -> all outputs return to reset values immediately (async), without waiting for a clock edge.
- With SIDE_BUF_STATS_EN: fill to 5, drain, starve once -> hwm=5, starve_events=1. Without the macro, the bench compiles without those ports.

Source files
------------

// File: rtl/side_buf_pkg.sv
// ============================================================================
// Module  : side_buf_pkg
// Brief   : Shared types, defaults and pointer helper for the side buffer FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package side_buf_pkg;

    localparam int unsigned c_DEF_FLIT_W = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        STARVED = 2'd2
    } state_t;

    // Explicit wrap at depth-1 so non-power-of-two depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/side_buf_mem.sv
// ============================================================================
// Module  : side_buf_mem
// Brief   : DEPTH x FLIT_W register array, one write port, async read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module side_buf_mem
    import side_buf_pkg::*;
#(
    parameter int FLIT_W = c_DEF_FLIT_W,
    parameter int DEPTH  = 6,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [FLIT_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [FLIT_W-1:0] rd_data
);

    logic [FLIT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/side_buffer_fifo.sv
// ============================================================================
// Module  : side_buffer_fifo
// Brief   : Circular side buffer with in-order reinjection and starvation-driven
//           redirect request. Optional stats outputs under SIDE_BUF_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module side_buffer_fifo
    import side_buf_pkg::*;
#(
    parameter int FLIT_W       = c_DEF_FLIT_W,
    parameter int DEPTH        = 6,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    input  logic              slot_free,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              force_redirect,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
`ifdef SIDE_BUF_STATS_EN
    ,
    output logic [CNT_W-1:0]  hwm,
    output logic [15:0]       starve_events
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SC_W-1:0] c_SC_MAX  = c_SC_W'(STARVE_LIMIT);
    localparam logic [c_SC_W-1:0] c_SC_TRIP = c_SC_W'(STARVE_LIMIT - 1);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [c_SC_W-1:0]  r_starve_cnt;
    state_t             r_state;
    logic               r_force;
    logic               w_push;
    logic               w_pop;
    logic               w_to_starved;

    assign empty          = (r_count == '0);
    assign full           = (r_count == CNT_W'(DEPTH));
    assign out_valid      = !empty;
    assign w_pop          = out_valid & slot_free;
    assign in_ready       = !full | w_pop;
    assign w_push         = in_valid & in_ready;
    assign count          = r_count;
    assign force_redirect = r_force;

    // Last blocked cycle in WAIT before the redirect request is raised.
    assign w_to_starved = (r_state == WAIT) && !w_pop && (r_starve_cnt == c_SC_TRIP) && !slot_free;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    side_buf_mem #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .PTR_W  (c_PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (in_flit),
        .rd_addr (r_rd_ptr),
        .rd_data (out_flit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= c_PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= c_PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_force      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_starve_cnt <= '0;
                    r_force      <= 1'b0;
                    if (w_push) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_pop) begin
                        r_starve_cnt <= '0;
                        if (w_count_nxt == '0) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        if (r_starve_cnt != c_SC_MAX) begin
                            r_starve_cnt <= r_starve_cnt + c_SC_W'(1);
                        end
                        if (w_to_starved) begin
                            r_state <= STARVED;
                            r_force <= 1'b1;
                        end
                    end
                end
                STARVED: begin
                    if (w_pop) begin
                        r_starve_cnt <= '0;
                        r_force      <= 1'b0;
                        r_state      <= (w_count_nxt == '0) ? IDLE : WAIT;
                    end else if (r_starve_cnt != c_SC_MAX) begin
                        r_starve_cnt <= r_starve_cnt + c_SC_W'(1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_starve_cnt <= '0;
                    r_force      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIDE_BUF_STATS_EN
    logic [CNT_W-1:0] r_hwm;
    logic [15:0]      r_starve_events;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hwm           <= '0;
            r_starve_events <= '0;
        end else begin
            if (w_count_nxt > r_hwm) begin
                r_hwm <= w_count_nxt;
            end
            if (w_to_starved && (r_starve_events != 16'hFFFF)) begin
                r_starve_events <= r_starve_events + 16'd1;
            end
        end
    end

    assign hwm           = r_hwm;
    assign starve_events = r_starve_events;
`endif

endmodule

`default_nettype wire

// File: tb/tb_side_buffer_fifo.sv
// ============================================================================
// Module  : tb_side_buffer_fifo
// Brief   : Scoreboard bench for side_buffer_fifo (stats checks under
//           SIDE_BUF_STATS_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_side_buffer_fifo;

    localparam int FLIT_W = 11;
    localparam int DEPTH  = 6;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [FLIT_W-1:0] in_flit = '0;
    logic              in_ready;
    logic              slot_free = 1'b0;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic              force_redirect;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
`ifdef SIDE_BUF_STATS_EN
    logic [CNT_W-1:0]  hwm;
    logic [15:0]       starve_events;
`endif

    int vectors = 0;
    int errors  = 0;
    logic [FLIT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    side_buffer_fifo #(
        .FLIT_W       (FLIT_W),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_flit        (in_flit),
        .in_ready       (in_ready),
        .slot_free      (slot_free),
        .out_valid      (out_valid),
        .out_flit       (out_flit),
        .force_redirect (force_redirect),
        .count          (count),
        .full           (full),
        .empty          (empty)
`ifdef SIDE_BUF_STATS_EN
        ,
        .hwm            (hwm),
        .starve_events  (starve_events)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every reinjection handshake pops the scoreboard in order.
    always @(negedge clk) begin
        if (rst_n && slot_free) begin
            if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_order: got %0h expected <none> at %0t", out_flit, $time);
                end else begin
                    logic [FLIT_W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_flit !== e) begin
                        errors++;
                        $display("FAIL pop_order: got %0h expected %0h at %0t", out_flit, e, $time);
                    end
                end
            end else if (exp_q.size() != 0) begin
                vectors++;
                errors++;
                $display("FAIL out_valid: got 0 expected 1 at %0t", $time);
            end
        end
    end

    // One clock of stimulus; starts and ends 1 time unit after a rising edge.
    task automatic cyc(input logic iv, input logic [FLIT_W-1:0] f, input logic sf, input logic exp_rdy);
        in_valid  = iv;
        in_flit   = f;
        slot_free = sf;
        @(negedge clk);
        if (iv) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (iv && exp_rdy) exp_q.push_back(f);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_force", 32'(force_redirect), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Two flits held, then released in order
        cyc(1'b1, 11'h123, 1'b0, 1'b1);
        cyc(1'b1, 11'h456, 1'b0, 1'b1);
        in_valid = 1'b0;
        chk("two_count", 32'(count), 2);
        chk("two_head", 32'(out_flit), 32'h123);
        chk("two_force", 32'(force_redirect), 0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);

        // Fill to full, refuse extra flit
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 11'h010 + 11'(i), 1'b0, 1'b1);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 6);
        cyc(1'b1, 11'h7FF, 1'b0, 1'b0);
        chk("refuse_count", 32'(count), 6);

        // Push+pop while full, across the write-pointer wrap
        cyc(1'b1, 11'h020, 1'b1, 1'b1);
        chk("pp_count0", 32'(count), 6);
        cyc(1'b1, 11'h021, 1'b1, 1'b1);
        chk("pp_count1", 32'(count), 6);
        chk("pp_head", 32'(out_flit), 32'h012);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("wrap_empty", 32'(empty), 1);

        // Starvation: one flit held with no free slot
        cyc(1'b1, 11'h0AA, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            if (k == 7 || k == 8 || k == 10) chk($sformatf("starve_force_%0d", k), 32'(force_redirect), 32'(k >= 8));
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("unstarve_force", 32'(force_redirect), 0);
        chk("unstarve_empty", 32'(empty), 1);

        // Async reset mid-stream with four flits and redirect active
        for (int i = 0; i < 4; i++) cyc(1'b1, 11'h030 + 11'(i), 1'b0, 1'b1);
        for (int k = 0; k < 20 && !force_redirect; k++) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst_force", 32'(force_redirect), 1);
        chk("pre_rst_count", 32'(count), 4);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_empty", 32'(empty), 1);
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_force", 32'(force_redirect), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef SIDE_BUF_STATS_EN
        for (int i = 0; i < 5; i++) cyc(1'b1, 11'h040 + 11'(i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 11'h055, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("stats_force", 32'(force_redirect), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("stats_hwm", 32'(hwm), 5);
        chk("stats_starve_events", 32'(starve_events), 1);
`endif

        chk("end_empty", 32'(empty), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
